// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS fetch stage: prioritised redirect, debug
// run/halt/step control, EPC capture and a circular return-address stack.
module pc_unit #(
  parameter int               NBITS        = 32,
  parameter logic [NBITS-1:0] RESET_VECTOR = NBITS'(32'h0000_0000),
  parameter logic [NBITS-1:0] EXC_VECTOR   = NBITS'(32'h0000_0180),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_PC_Write,
  input  logic             i_branch_taken,
  input  logic [NBITS-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [NBITS-1:0] i_jump_target,
  input  logic             i_exception,
  input  logic             i_eret,
  input  logic             i_ras_push,
  input  logic             i_ras_pop,
  input  logic             i_halt,
  input  logic             i_step_mode,
  input  logic             i_step,
  output logic [NBITS-1:0] o_PC,
  output logic [NBITS-1:0] o_PC_4,
  output logic [NBITS-1:0] o_PC_8,
  output logic [NBITS-1:0] o_epc,
  output logic [NBITS-1:0] o_ras_top,
  output logic             o_ras_valid,
  output logic             o_ras_full,
  output logic             o_halted
);

  localparam int PTRW = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(RAS_DEPTH);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_unit: RAS_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t           state;
  logic             halted_q;
  logic [NBITS-1:0] pc_q;
  logic [NBITS-1:0] epc_q;

  logic [NBITS-1:0] ras_mem [RAS_DEPTH];
  logic [PTRW-1:0]  ras_ptr;
  logic [CNTW-1:0]  ras_cnt;

  logic             adv;
  logic             ras_en;
  logic             do_push;
  logic             do_pop;
  logic             ras_empty;
  logic [PTRW-1:0]  ptr_inc;
  logic [PTRW-1:0]  ptr_dec;

  assign adv = i_PC_Write & (((state == ST_RUN) & ~i_halt) | (state == ST_STEP));

  assign o_PC   = pc_q;
  assign o_PC_4 = pc_q + NBITS'(4);
  assign o_PC_8 = pc_q + NBITS'(8);
  assign o_epc  = epc_q;
  assign o_halted = halted_q;

  // The stack only moves on instructions that actually leave fetch, never on a trap.
  assign ras_en    = adv & ~i_exception;
  assign do_push   = ras_en & i_ras_push;
  assign do_pop    = ras_en & i_ras_pop;
  assign ras_empty = (ras_cnt == '0);
  assign ptr_inc   = ras_ptr + PTRW'(1);
  assign ptr_dec   = ras_ptr - PTRW'(1);

  assign o_ras_top   = ras_empty ? '0 : ras_mem[ras_ptr];
  assign o_ras_valid = ~ras_empty;
  assign o_ras_full  = (ras_cnt == DEPTH_C);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_RUN;
      halted_q <= 1'b0;
    end else if (i_exception) begin
      state    <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (i_halt || i_step_mode) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          // A pending halt request outranks both resume and step.
          if (i_halt) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else if (!i_step_mode) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
          end else if (i_step) begin
            state    <= ST_STEP;
            halted_q <= 1'b0;
          end
        end
        ST_STEP: begin
          state    <= ST_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
    end else if (i_exception) begin
      epc_q <= pc_q;
      pc_q  <= EXC_VECTOR;
    end else if (adv) begin
      if (i_eret) begin
        pc_q <= epc_q;
      end else if (i_branch_taken) begin
        pc_q <= i_branch_target;
      end else if (i_jump) begin
        pc_q <= i_jump_target;
      end else begin
        pc_q <= o_PC_4;
      end
    end
  end

  // Push on a full stack overwrites the oldest entry; the pointer simply wraps.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          ras_mem[ptr_inc] <= o_PC_8;
          ras_ptr          <= ptr_inc;
          if (ras_cnt != DEPTH_C) begin
            ras_cnt <= ras_cnt + CNTW'(1);
          end
        end
        2'b01: begin
          if (!ras_empty) begin
            ras_ptr <= ptr_dec;
            ras_cnt <= ras_cnt - CNTW'(1);
          end
        end
        2'b11: begin
          if (ras_empty) begin
            ras_mem[ptr_inc] <= o_PC_8;
            ras_ptr          <= ptr_inc;
            ras_cnt          <= CNTW'(1);
          end else begin
            ras_mem[ras_ptr] <= o_PC_8;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit: a cycle-by-cycle table plus hand-written
// sequences for debug stepping and asynchronous reset.
module tb_pc_unit;

  typedef struct {
    logic        w;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        exc;
    logic        eret;
    logic        push;
    logic        pop;
    logic        halt;
    logic        sm;
    logic        step;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] top;
    logic        valid;
    logic        full;
    logic        halted;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        pc_write, branch_taken, jump, exception, eret;
  logic        ras_push, ras_pop, halt, step_mode, step;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_4, pc_8, epc, ras_top;
  logic        ras_valid, ras_full, halted;

  int applied = 0;
  int miscompares = 0;
  vec_t tbl[$];

  pc_unit #(
    .NBITS(32),
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR(32'h0000_0180),
    .RAS_DEPTH(4)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_PC_Write(pc_write),
    .i_branch_taken(branch_taken),
    .i_branch_target(branch_target),
    .i_jump(jump),
    .i_jump_target(jump_target),
    .i_exception(exception),
    .i_eret(eret),
    .i_ras_push(ras_push),
    .i_ras_pop(ras_pop),
    .i_halt(halt),
    .i_step_mode(step_mode),
    .i_step(step),
    .o_PC(pc),
    .o_PC_4(pc_4),
    .o_PC_8(pc_8),
    .o_epc(epc),
    .o_ras_top(ras_top),
    .o_ras_valid(ras_valid),
    .o_ras_full(ras_full),
    .o_halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(
    input logic w, input logic br, input logic [31:0] bt, input logic j, input logic [31:0] jt,
    input logic exc, input logic er, input logic pu, input logic po,
    input logic hl, input logic sm, input logic st,
    input logic [31:0] xpc, input logic [31:0] xepc, input logic [31:0] xtop,
    input logic xv, input logic xf, input logic xh);
    vec_t v;
    v.w = w; v.br = br; v.bt = bt; v.j = j; v.jt = jt;
    v.exc = exc; v.eret = er; v.push = pu; v.pop = po;
    v.halt = hl; v.sm = sm; v.step = st;
    v.pc = xpc; v.epc = xepc; v.top = xtop;
    v.valid = xv; v.full = xf; v.halted = xh;
    return v;
  endfunction

  task automatic driveInputs(input vec_t v);
    pc_write = v.w;
    branch_taken = v.br;
    branch_target = v.bt;
    jump = v.j;
    jump_target = v.jt;
    exception = v.exc;
    eret = v.eret;
    ras_push = v.push;
    ras_pop = v.pop;
    halt = v.halt;
    step_mode = v.sm;
    step = v.step;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [31:0] exp4, exp8;
    exp4 = v.pc + 32'd4;
    exp8 = v.pc + 32'd8;
    applied++;
    if (pc !== v.pc || pc_4 !== exp4 || pc_8 !== exp8 || epc !== v.epc || ras_top !== v.top ||
        ras_valid !== v.valid || ras_full !== v.full || halted !== v.halted) begin
      miscompares++;
      $display("[TB] FAIL %s: got pc=%h pc4=%h pc8=%h epc=%h top=%h valid=%b full=%b halted=%b, want pc=%h pc4=%h pc8=%h epc=%h top=%h valid=%b full=%b halted=%b",
               name, pc, pc_4, pc_8, epc, ras_top, ras_valid, ras_full, halted,
               v.pc, exp4, exp8, v.epc, v.top, v.valid, v.full, v.halted);
    end
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    driveInputs(v);
    @(posedge clk);
    #1;
    checkOutput(name, v);
  endtask

  task automatic doReset();
    driveInputs(mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 32'h0,0,0, 0,0,0));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    driveInputs(mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0));

    // Free run, branch/jump priority, stall, exception and ERET.
    for (int k = 1; k <= 8; k++) begin
      tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 32'(4*k),0,0, 0,0,0));
    end
    tbl.push_back(mk(1,1,'h100,1,'h200, 0,0,0,0, 0,0,0, 'h100,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,1,'h200,     0,0,0,0, 0,0,0, 'h100,0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,1,'h40,      0,0,0,0, 0,0,0, 'h40,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,         1,0,0,0, 0,0,0, 'h180,'h40,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,0,0, 0,0,0, 'h184,'h40,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,0,0, 0,0,0, 'h188,'h40,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,1,0,0, 0,0,0, 'h40,'h40,0, 0,0,0));
    // RAS fill past capacity, then drain past empty.
    tbl.push_back(mk(1,0,0,1,'h0,       0,0,0,0, 0,0,0, 'h0,'h40,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,1,0, 0,0,0, 'h4,'h40,'h8, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,1,0, 0,0,0, 'h8,'h40,'hc, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,1,0, 0,0,0, 'hc,'h40,'h10, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,1,0, 0,0,0, 'h10,'h40,'h14, 1,1,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,1,0, 0,0,0, 'h14,'h40,'h18, 1,1,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,0,1, 0,0,0, 'h18,'h40,'h14, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,0,1, 0,0,0, 'h1c,'h40,'h10, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,0,1, 0,0,0, 'h20,'h40,'hc, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,0,1, 0,0,0, 'h24,'h40,'h0, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,0,1, 0,0,0, 'h28,'h40,'h0, 0,0,0));
    // Simultaneous push/pop, suppression on exception and stall.
    tbl.push_back(mk(1,0,0,1,'h30,      0,0,0,0, 0,0,0, 'h30,'h40,'h0, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,1,1, 0,0,0, 'h34,'h40,'h38, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,         1,0,1,0, 0,0,0, 'h180,'h34,'h38, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,         0,0,1,0, 0,0,0, 'h180,'h34,'h38, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,1,1, 0,0,0, 'h184,'h34,'h188, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,0,1, 0,0,0, 'h188,'h34,'h0, 0,0,0));
    tbl.push_back(mk(1,1,'h500,0,0,     0,1,0,0, 0,0,0, 'h34,'h34,'h0, 0,0,0));
    // PC wraps modulo 2^32.
    tbl.push_back(mk(1,0,0,1,'hFFFF_FFFC, 0,0,0,0, 0,0,0, 'hFFFF_FFFC,'h34,'h0, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0,         0,0,0,0, 0,0,0, 'h0,'h34,'h0, 0,0,0));

    doReset();
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus($sformatf("row%0d", i), tbl[i]);
    end

    // Halt, single-step, resume, step_mode while running, exception out of HALT.
    doReset();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus("step_run", mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 32'(4*k),0,0, 0,0,0));
    end
    applyStimulus("halt_enter", mk(1,0,0,0,0, 0,0,0,0, 1,1,0, 'h10,0,0, 0,0,1));
    for (int k = 0; k < 3; k++) begin
      applyStimulus("halt_idle", mk(1,0,0,0,0, 0,0,0,0, 0,1,0, 'h10,0,0, 0,0,1));
    end
    applyStimulus("halt_beats_step", mk(1,0,0,0,0, 0,0,0,0, 1,1,1, 'h10,0,0, 0,0,1));
    applyStimulus("step_enter",  mk(1,0,0,0,0, 0,0,0,0, 0,1,1, 'h10,0,0, 0,0,0));
    applyStimulus("step_adv",    mk(1,0,0,0,0, 0,0,0,0, 0,1,0, 'h14,0,0, 0,0,1));
    applyStimulus("step_hold",   mk(1,0,0,0,0, 0,0,0,0, 0,1,0, 'h14,0,0, 0,0,1));
    applyStimulus("resume",      mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 'h14,0,0, 0,0,0));
    applyStimulus("run_a",       mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 'h18,0,0, 0,0,0));
    applyStimulus("run_b",       mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 'h1c,0,0, 0,0,0));
    applyStimulus("sm_in_run",   mk(1,0,0,0,0, 0,0,0,0, 0,1,0, 'h20,0,0, 0,0,1));
    applyStimulus("exc_halted",  mk(0,0,0,0,0, 1,0,0,0, 0,0,0, 'h180,'h20,0, 0,0,0));
    applyStimulus("post_exc",    mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 'h184,'h20,0, 0,0,0));
    applyStimulus("halt_again",  mk(1,0,0,1,'h300, 0,0,1,0, 1,0,0, 'h184,'h20,0, 0,0,1));

    // Reset dropped mid-cycle while halted takes effect without a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 'h0,0,0, 0,0,0));
    #2;
    rst_n = 1'b1;
    applyStimulus("after_reset", mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 'h4,0,0, 0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
